wb_regfile: RTL

Writeback-side consumer of the MEM/WB pipeline register, combined with the architectural register file.
- Selects the writeback value (memory load data or ALU result) and commits it to a 32-entry register file on the clock edge.
- Serves two combinational read ports to the ID stage, with write-through bypass so a same-cycle WB write is visible to ID.
- Provides a debug read port, a last-commit record and a commit counter for bench checking.

---
 rtl/wb_regfile.sv | 87 ++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback stage with a 32-entry register file: selects the writeback value,
// commits it, serves two bypassed ID read ports, a debug port and commit stats.
module wb_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_wb,
    input  logic              mem_to_reg_wb,
    input  logic [DATA_W-1:0] read_data_wb,
    input  logic [DATA_W-1:0] alu_result_wb,
    input  logic [ADDR_W-1:0] write_reg_wb,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [ADDR_W-1:0] last_wr_reg,
    output logic [DATA_W-1:0] last_wr_data,
    output logic [31:0]       commit_count
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [ADDR_W-1:0] last_reg_q, last_reg_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [31:0]       count_q, count_d;

    assign wb_data   = mem_to_reg_wb ? read_data_wb : alu_result_wb;
    // Gating with reset both drops writes in the reset cycle and disables bypass.
    assign wb_commit = reset && reg_write_wb && (write_reg_wb != '0);

    always_comb begin
        rs_data  = '0;
        rt_data  = '0;
        dbg_data = '0;
        if (rs_addr != '0) begin
            if (wb_commit && (write_reg_wb == rs_addr)) rs_data = wb_data;
            else                                        rs_data = regs_q[rs_addr];
        end
        if (rt_addr != '0) begin
            if (wb_commit && (write_reg_wb == rt_addr)) rt_data = wb_data;
            else                                        rt_data = regs_q[rt_addr];
        end
        if (dbg_addr != '0) dbg_data = regs_q[dbg_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_commit) begin
            regs_q[write_reg_wb] <= wb_data;
        end
    end

    always_comb begin
        last_reg_d  = last_reg_q;
        last_data_d = last_data_q;
        count_d     = count_q;
        if (wb_commit) begin
            last_reg_d  = write_reg_wb;
            last_data_d = wb_data;
            if (count_q != '1) count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_reg_q  <= '0;
            last_data_q <= '0;
            count_q     <= '0;
        end else begin
            last_reg_q  <= last_reg_d;
            last_data_q <= last_data_d;
            count_q     <= count_d;
        end
    end

    assign last_wr_reg  = last_reg_q;
    assign last_wr_data = last_data_q;
    assign commit_count = count_q;

endmodule
